// File: rtl/dkong3_audio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dkong3_audio_pkg
// Purpose  : Shared widths, FSM state encoding and saturation helper for the
//            Donkey Kong 3 audio output stage.
// Revision : 1.0 - initial release
// ============================================================================
package dkong3_audio_pkg;

    localparam int SAMPLE_W = 16;
    localparam int DCB_W    = 21;
    localparam int Y_W      = 20;
    localparam int VOL_W    = 3;
    localparam int GAIN_W   = 4;
    localparam int PROD_W   = 24;
    localparam int CALC_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DCB   = 2'd1,
        ST_SCALE = 2'd2,
        ST_OUT   = 2'd3
    } audio_state_e;

    function automatic logic signed [CALC_W-1:0] saturate(
        input logic signed [CALC_W-1:0] x,
        input logic signed [CALC_W-1:0] hi,
        input logic signed [CALC_W-1:0] lo
    );
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dkong3_sat.sv
`default_nettype none
// ============================================================================
// Module   : dkong3_sat
// Purpose  : Signed saturator, IN_W -> OUT_W bits, with a clip indication.
//            SYMMETRIC=1 limits to +/-(2^(OUT_W-1)-1).
// Revision : 1.0 - initial release
// ============================================================================
module dkong3_sat
    import dkong3_audio_pkg::*;
#(
    parameter int IN_W      = 21,
    parameter int OUT_W     = 20,
    parameter bit SYMMETRIC = 1'b1
) (
    input  logic signed [IN_W-1:0]  data_i,
    output logic signed [OUT_W-1:0] data_o,
    output logic                    clip_o
);

    localparam logic signed [CALC_W-1:0] c_SAT_HI = (32'sd1 <<< (OUT_W - 1)) - 32'sd1;
    localparam logic signed [CALC_W-1:0] c_SAT_LO = SYMMETRIC ? -c_SAT_HI : -c_SAT_HI - 32'sd1;

    logic signed [CALC_W-1:0] w_ext;
    logic signed [CALC_W-1:0] w_sat;

    assign w_ext  = {{(CALC_W - IN_W){data_i[IN_W-1]}}, data_i};
    assign w_sat  = saturate(w_ext, c_SAT_HI, c_SAT_LO);
    assign data_o = w_sat[OUT_W-1:0];
    assign clip_o = (w_sat != w_ext);

endmodule
`default_nettype wire

// File: rtl/dkong3_audio_out.sv
`default_nettype none
// ============================================================================
// Module   : dkong3_audio_out
// Purpose  : Decimating averager, DC blocker, volume scaler and mute for the
//            mixed sound-subsystem sample stream.
// Revision : 1.0 - initial release
// ============================================================================
module dkong3_audio_out
    import dkong3_audio_pkg::*;
#(
    parameter int DECIM_LOG2 = 5,
    parameter int DCB_K      = 10
) (
    input  logic                       I_CLK_24M,
    input  logic                       I_RESET,
    input  logic signed [SAMPLE_W-1:0] I_SAMPLE,
    input  logic                       I_SAMPLE_CE,
    input  logic [VOL_W-1:0]           I_VOLUME,
    input  logic                       I_MUTE,
    output logic signed [SAMPLE_W-1:0] O_SAMPLE,
    output logic                       O_VALID,
    output logic                       O_CLIP
);

    localparam int c_ACC_W = SAMPLE_W + DECIM_LOG2;

    audio_state_e state_q, state_d;

    logic signed [c_ACC_W-1:0]  acc_q, acc_d;
    logic [DECIM_LOG2-1:0]      cnt_q, cnt_d;
    logic signed [SAMPLE_W-1:0] avg_q, avg_d;
    logic signed [SAMPLE_W-1:0] avg_prev_q, avg_prev_d;
    logic signed [Y_W-1:0]      y_prev_q, y_prev_d;
    logic signed [SAMPLE_W-1:0] p_q, p_d;
    logic signed [SAMPLE_W-1:0] sample_q, sample_d;
    logic                       valid_q, valid_d;
    logic                       clip_q, clip_d;

    logic signed [c_ACC_W-1:0]  w_sample_ext;
    logic signed [c_ACC_W-1:0]  w_acc_sum;
    logic                       w_wrap;
    logic signed [DCB_W-1:0]    w_avg_x, w_avgp_x, w_yp_x, w_yp_shift, w_dcb_raw;
    logic signed [Y_W-1:0]      w_y_sat;
    logic                       w_clip_dcb;
    logic [GAIN_W-1:0]          w_gain;
    logic signed [PROD_W-1:0]   w_y_x, w_gain_x, w_prod;
    logic signed [SAMPLE_W-1:0] w_p_sat;
    logic                       w_clip_scale;

    assign w_sample_ext = {{DECIM_LOG2{I_SAMPLE[SAMPLE_W-1]}}, I_SAMPLE};
    assign w_acc_sum    = acc_q + w_sample_ext;
    assign w_wrap       = I_SAMPLE_CE && (cnt_q == '1);

    // y = avg - avg_prev + y_prev - y_prev/2^K, all sign-extended to 21 bits
    assign w_avg_x    = {{(DCB_W - SAMPLE_W){avg_q[SAMPLE_W-1]}}, avg_q};
    assign w_avgp_x   = {{(DCB_W - SAMPLE_W){avg_prev_q[SAMPLE_W-1]}}, avg_prev_q};
    assign w_yp_x     = {{(DCB_W - Y_W){y_prev_q[Y_W-1]}}, y_prev_q};
    assign w_yp_shift = w_yp_x >>> DCB_K;
    assign w_dcb_raw  = w_avg_x - w_avgp_x + w_yp_x - w_yp_shift;

    dkong3_sat #(
        .IN_W      (DCB_W),
        .OUT_W     (Y_W),
        .SYMMETRIC (1'b1)
    ) u_sat_dcb (
        .data_i (w_dcb_raw),
        .data_o (w_y_sat),
        .clip_o (w_clip_dcb)
    );

    // Gain is (vol+1)/4; the low two product bits are the floor shift.
    assign w_gain   = {1'b0, I_VOLUME} + 4'd1;
    assign w_y_x    = {{(PROD_W - Y_W){y_prev_q[Y_W-1]}}, y_prev_q};
    assign w_gain_x = {{(PROD_W - GAIN_W){1'b0}}, w_gain};
    assign w_prod   = w_y_x * w_gain_x;

    dkong3_sat #(
        .IN_W      (PROD_W - 2),
        .OUT_W     (SAMPLE_W),
        .SYMMETRIC (1'b0)
    ) u_sat_scale (
        .data_i (w_prod[PROD_W-1:2]),
        .data_o (w_p_sat),
        .clip_o (w_clip_scale)
    );

    always_ff @(posedge I_CLK_24M) begin
        if (I_RESET)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        avg_d      = avg_q;
        avg_prev_d = avg_prev_q;
        y_prev_d   = y_prev_q;
        p_d        = p_q;
        sample_d   = sample_q;
        valid_d    = 1'b0;
        clip_d     = clip_q;
        state_d    = state_q;

        // Accumulation runs regardless of where the FSM is.
        if (I_SAMPLE_CE) begin
            cnt_d = cnt_q + DECIM_LOG2'(1);
            acc_d = w_wrap ? '0 : w_acc_sum;
        end
        if (w_wrap)
            avg_d = w_acc_sum[c_ACC_W-1:DECIM_LOG2];

        case (state_q)
            ST_IDLE: begin
                if (w_wrap)
                    state_d = ST_DCB;
            end
            ST_DCB: begin
                y_prev_d   = w_y_sat;
                avg_prev_d = avg_q;
                clip_d     = clip_q | w_clip_dcb;
                state_d    = ST_SCALE;
            end
            ST_SCALE: begin
                p_d     = w_p_sat;
                clip_d  = clip_q | w_clip_scale;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                sample_d = I_MUTE ? '0 : p_q;
                valid_d  = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK_24M) begin
        if (I_RESET) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            avg_q      <= '0;
            avg_prev_q <= '0;
            y_prev_q   <= '0;
            p_q        <= '0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            clip_q     <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            avg_q      <= avg_d;
            avg_prev_q <= avg_prev_d;
            y_prev_q   <= y_prev_d;
            p_q        <= p_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            clip_q     <= clip_d;
        end
    end

    assign O_SAMPLE = sample_q;
    assign O_VALID  = valid_q;
    assign O_CLIP   = clip_q;

endmodule
`default_nettype wire

// File: tb/tb_dkong3_audio_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_dkong3_audio_out
// Purpose  : Self-checking bench; two instances (DECIM_LOG2=2 and 1) share
//            stimulus and are compared against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dkong3_audio_out;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic signed [15:0] sample = '0;
    logic               ce = 1'b0;
    logic [2:0]         vol = 3'd3;
    logic               mute = 1'b0;

    logic signed [15:0] o_s [2];
    logic               o_v [2];
    logic               o_c [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dkong3_audio_out #(.DECIM_LOG2(2), .DCB_K(10)) dut0 (
        .I_CLK_24M(clk), .I_RESET(rst), .I_SAMPLE(sample), .I_SAMPLE_CE(ce),
        .I_VOLUME(vol), .I_MUTE(mute),
        .O_SAMPLE(o_s[0]), .O_VALID(o_v[0]), .O_CLIP(o_c[0])
    );

    dkong3_audio_out #(.DECIM_LOG2(1), .DCB_K(10)) dut1 (
        .I_CLK_24M(clk), .I_RESET(rst), .I_SAMPLE(sample), .I_SAMPLE_CE(ce),
        .I_VOLUME(vol), .I_MUTE(mute),
        .O_SAMPLE(o_s[1]), .O_VALID(o_v[1]), .O_CLIP(o_c[1])
    );

    // Reference model state, one slot per instance.
    longint m_sum [2];
    int     m_cnt [2];
    longint m_avgp [2];
    longint m_yp [2];
    bit     m_clip [2];
    longint m_out [2];
    logic signed [15:0] obs0 [$];
    logic signed [15:0] obs1 [$];

    function automatic longint fdiv(input longint a, input longint n);
        longint q;
        q = a / n;
        if ((a % n) != 0 && a < 0)
            q = q - 1;
        return q;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_sum[i] = 0; m_cnt[i] = 0; m_avgp[i] = 0;
            m_yp[i] = 0; m_clip[i] = 0; m_out[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input longint s, output bit wrap);
        longint n, avg, y, p;
        n = (i == 0) ? 4 : 2;
        m_sum[i] += s;
        m_cnt[i]++;
        wrap = 1'b0;
        if (m_cnt[i] == n) begin
            wrap = 1'b1;
            avg = fdiv(m_sum[i], n);
            m_sum[i] = 0;
            m_cnt[i] = 0;
            y = avg - m_avgp[i] + m_yp[i] - fdiv(m_yp[i], 1024);
            if (y > 524287) begin y = 524287; m_clip[i] = 1; end
            else if (y < -524287) begin y = -524287; m_clip[i] = 1; end
            m_yp[i] = y;
            m_avgp[i] = avg;
            p = fdiv(y * (longint'(vol) + 1), 4);
            if (p > 32767) begin p = 32767; m_clip[i] = 1; end
            else if (p < -32768) begin p = -32768; m_clip[i] = 1; end
            m_out[i] = mute ? 0 : p;
        end
    endtask

    // One strobe followed by three quiet cycles; watches every cycle.
    task automatic do_strobe(input logic signed [15:0] s);
        bit                 wr [2];
        longint             prev [2];
        logic               exp_v;
        logic signed [15:0] exp_s;
        for (int i = 0; i < 2; i++) begin
            prev[i] = m_out[i];
            model_step(i, longint'(s), wr[i]);
        end
        @(negedge clk);
        sample = s;
        ce = 1'b1;
        @(posedge clk); #1;
        ce = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                exp_v = (k == 3) && wr[i];
                exp_s = (k < 3) ? 16'(prev[i]) : 16'(m_out[i]);
                checks++;
                if (o_v[i] !== exp_v) begin
                    errors++;
                    $display("FAIL valid[%0d] cyc%0d: got %b want %b", i, k, o_v[i], exp_v);
                end
                checks++;
                if (o_s[i] !== exp_s) begin
                    errors++;
                    $display("FAIL sample[%0d] cyc%0d: got %0d want %0d", i, k, o_s[i], exp_s);
                end
                if (k == 3) begin
                    checks++;
                    if (o_c[i] !== m_clip[i]) begin
                        errors++;
                        $display("FAIL clip[%0d]: got %b want %b", i, o_c[i], m_clip[i]);
                    end
                end
                if (o_v[i] === 1'b1) begin
                    if (i == 0) obs0.push_back(o_s[i]);
                    else        obs1.push_back(o_s[i]);
                end
            end
        end
    endtask

    // Reset is held with a strobe present so it must be ignored.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ce = 1'b1;
        sample = 16'sh7FFF;
        @(posedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        ce = 1'b0;
        model_clear();
        obs0.delete();
        obs1.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        ce = 1'b1;
        sample = 16'sh7FFF;
        @(posedge clk);
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (o_s[i] !== 16'sd0 || o_v[i] !== 1'b0 || o_c[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state[%0d]: got s=%0d v=%b c=%b want 0/0/0", i, o_s[i], o_v[i], o_c[i]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        ce = 1'b0;
        model_clear();
        obs0.delete();
        obs1.delete();
    endtask

    task automatic test_dc_step();
        do_reset();
        vol = 3'd3; mute = 1'b0;
        repeat (8) do_strobe(16'sh1000);
        checks++;
        if (obs0.size() != 2) begin
            errors++;
            $display("FAIL dc_count: got %0d want 2", obs0.size());
        end else begin
            checks++;
            if (obs0[0] !== 16'sh1000) begin
                errors++;
                $display("FAIL dc_first: got %h want 1000", obs0[0]);
            end
            checks++;
            if (obs0[1] !== 16'sh0FFC) begin
                errors++;
                $display("FAIL dc_second: got %h want 0ffc", obs0[1]);
            end
        end
        checks++;
        if (o_c[0] !== 1'b0) begin
            errors++;
            $display("FAIL dc_clip: got %b want 0", o_c[0]);
        end
    endtask

    task automatic test_clip();
        do_reset();
        vol = 3'd7; mute = 1'b0;
        repeat (4) do_strobe(16'sh7FFF);
        checks++;
        if (obs0.size() != 1 || obs0[0] !== 16'sh7FFF || o_c[0] !== 1'b1) begin
            errors++;
            $display("FAIL clip_first: got n=%0d s=%h c=%b want n=1 s=7fff c=1",
                     obs0.size(), (obs0.size() > 0) ? obs0[0] : 16'sh0, o_c[0]);
        end
        vol = 3'd0;
        repeat (8) do_strobe(16'sh0000);
        checks++;
        if (o_c[0] !== 1'b1) begin
            errors++;
            $display("FAIL clip_sticky: got %b want 1", o_c[0]);
        end
    endtask

    task automatic test_cadence();
        do_reset();
        mute = 1'b0;
        for (int n = 0; n < 16; n++) begin
            vol = 3'($urandom_range(0, 7));
            do_strobe(16'($urandom_range(0, 16'hFFFF)));
        end
        checks++;
        if (obs0.size() != 4 || obs1.size() != 8) begin
            errors++;
            $display("FAIL cadence_count: got %0d/%0d want 4/8", obs0.size(), obs1.size());
        end
    endtask

    task automatic test_mute();
        do_reset();
        vol = 3'd3;
        mute = 1'b1;
        repeat (4) do_strobe(16'sh1000);
        mute = 1'b0;
        repeat (4) do_strobe(16'sh1000);
        checks++;
        if (obs0.size() != 2 || obs0[0] !== 16'sh0 || obs0[1] !== 16'sh0FFC) begin
            errors++;
            $display("FAIL mute_seq: got n=%0d s0=%h s1=%h want n=2 0000 0ffc", obs0.size(),
                     (obs0.size() > 0) ? obs0[0] : 16'sh0, (obs0.size() > 1) ? obs0[1] : 16'sh0);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        vol = 3'd3; mute = 1'b0;
        repeat (7) do_strobe(16'sh1000);
        @(negedge clk);
        sample = 16'sh1000;
        ce = 1'b1;
        @(posedge clk); #1;
        ce = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            rst = 1'b0;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (o_v[i] !== 1'b0 || o_s[i] !== 16'sd0 || o_c[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL midreset[%0d] cyc%0d: got v=%b s=%0d c=%b want 0/0/0",
                             i, k, o_v[i], o_s[i], o_c[i]);
                end
            end
        end
        model_clear();
        obs0.delete();
        obs1.delete();
        repeat (4) do_strobe(16'sh1000);
        checks++;
        if (obs0.size() != 1 || obs0[0] !== 16'sh1000) begin
            errors++;
            $display("FAIL midreset_fresh: got n=%0d s=%h want n=1 1000",
                     obs0.size(), (obs0.size() > 0) ? obs0[0] : 16'sh0);
        end
    endtask

    task automatic test_alternating();
        do_reset();
        vol = 3'($urandom_range(0, 7));
        mute = 1'b0;
        for (int n = 0; n < 8; n++)
            do_strobe(n[0] ? -16'sh0100 : 16'sh0100);
        checks++;
        if (obs1.size() != 4) begin
            errors++;
            $display("FAIL alt_count: got %0d want 4", obs1.size());
        end
        foreach (obs1[j]) begin
            checks++;
            if (obs1[j] !== 16'sd0) begin
                errors++;
                $display("FAIL alt_zero[%0d]: got %0d want 0", j, obs1[j]);
            end
        end
    endtask

    task automatic test_random();
        logic signed [15:0] s;
        do_reset();
        for (int n = 0; n < 64; n++) begin
            vol  = 3'($urandom_range(0, 7));
            mute = ($urandom_range(0, 7) == 0);
            s = 16'($urandom_range(0, 16'hFFFF));
            if ($urandom_range(0, 1) == 1)
                s = s >>> 4;
            do_strobe(s);
        end
    endtask

    initial begin
        test_reset();
        test_dc_step();
        test_clip();
        test_cadence();
        test_mute();
        test_reset_mid();
        test_alternating();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dkong3_audio_out.md
DKONG3_AUDIO_OUT -- requirements
Module: dkong3_audio_out

Interface
REQ-001 SHALL have parameter DECIM_LOG2, default 5: the decimation factor is 2^DECIM_LOG2 input samples per output.
REQ-002 SHALL have parameter DCB_K, default 10: the DC-blocker pole shift, giving pole = 1 - 2^-DCB_K.
REQ-003 SHALL have port I_CLK_24M, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port I_RESET, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port I_SAMPLE, input, signed 16 bits: the mixed sound-subsystem sample.
REQ-006 SHALL have port I_SAMPLE_CE, input, 1 bit: one-cycle strobe marking I_SAMPLE valid; strobes are always at least 4 cycles apart.
REQ-007 SHALL have port I_VOLUME, input, 3 bits: gain = (I_VOLUME+1)/4, so 0.25 to 2.0.
REQ-008 SHALL have port I_MUTE, input, 1 bit: forces output samples to zero.
REQ-009 SHALL have port O_SAMPLE, output, signed 16 bits: the filtered, scaled sample, held between updates.
REQ-010 SHALL have port O_VALID, output, 1 bit: one-cycle pulse marking a new O_SAMPLE.
REQ-011 SHALL have port O_CLIP, output, 1 bit: sticky flag set when any saturation occurs.

Function
REQ-012 SHALL add I_SAMPLE into a signed accumulator of width 16+DECIM_LOG2 on each I_SAMPLE_CE, and count strobes with a DECIM_LOG2-bit counter.
REQ-013 SHALL, on the strobe that wraps the counter from 2^DECIM_LOG2-1 to 0, snapshot the sum including that sample as avg = sum >>> DECIM_LOG2 (arithmetic shift, floor), clear the accumulator to 0, and start the FSM.
REQ-014 SHALL use the FSM states IDLE, DCB, SCALE and OUT, with transitions IDLE->DCB on snapshot, then DCB->SCALE->OUT->IDLE unconditionally, one cycle each.
REQ-015 SHALL in DCB compute y = avg - avg_prev + y_prev - (y_prev >>> DCB_K) in 21-bit signed arithmetic, saturate it to a signed 20-bit range (+/-(2^19-1)), store it as y_prev, and store avg as avg_prev.
REQ-016 SHALL in SCALE compute p = (y * (I_VOLUME+1)) >>> 2, sampling I_VOLUME in this state, and saturate p to the range -32768..32767.
REQ-017 SHALL in OUT load O_SAMPLE with p, or with 0 if I_MUTE=1, and assert O_VALID for exactly this cycle.
REQ-018 SHALL make latency from the snapshotting I_SAMPLE_CE edge to O_VALID exactly 3 cycles.
REQ-019 SHALL leave filter state (avg_prev, y_prev) updated while I_MUTE=1, so unmute causes no transient.
REQ-020 SHALL keep accumulation running independently of the FSM; an I_SAMPLE_CE arriving while the FSM is in DCB, SCALE or OUT is accumulated normally.
REQ-021 SHALL set O_CLIP when either saturation in REQ-015 or REQ-016 engages; O_CLIP clears only on reset.
REQ-022 SHALL hold O_SAMPLE unchanged outside the OUT state.

Reset
REQ-023 SHALL, with I_RESET=1 at a clock edge, clear the accumulator, counter, avg_prev, y_prev, O_SAMPLE, O_VALID and O_CLIP to 0, and set the FSM to IDLE.
REQ-024 SHALL, on reset mid-window or mid-FSM, discard partial work, emit no O_VALID, and start the next window counting from 0.
REQ-025 SHALL ignore I_SAMPLE_CE in any cycle where I_RESET=1.

Structure
REQ-026 SHALL place the width constants, the FSM state enum and a saturate function in shared package dkong3_audio_pkg.
REQ-027 SHALL contain one sub-module, dkong3_sat, a parameterised signed saturator with a clip flag, instantiated for the REQ-015 and REQ-016 stages.

Verification
REQ-028 SHALL cover: DECIM_LOG2=2, DCB_K=10, I_VOLUME=3, constant I_SAMPLE=0x1000 -> first O_SAMPLE=0x1000, second=0x0FFC (4092), O_CLIP=0.
REQ-029 SHALL cover: I_SAMPLE=0x7FFF constant, I_VOLUME=7 -> first O_SAMPLE=0x7FFF, O_CLIP=1 and stays 1.
REQ-030 SHALL cover: I_SAMPLE_CE spaced 4 cycles apart, DECIM_LOG2=2 -> O_VALID exactly 3 cycles after every 4th strobe, no missed or extra pulses.
REQ-031 SHALL cover: I_MUTE=1 for one output period, then 0, with constant input -> muted O_SAMPLE=0, next O_SAMPLE equals the unmuted reference sequence value.
REQ-032 SHALL cover: I_RESET pulsed during SCALE -> no O_VALID, O_SAMPLE=0, next window's first output matches a fresh-after-reset output.
REQ-033 SHALL cover: I_SAMPLE alternating +0x0100/-0x0100, DECIM_LOG2=1 -> avg=0 on every output, O_SAMPLE=0.
